// File: rtl/lcd_pkg.sv
// Shared constants, types and helpers for the character-LCD bus capture block.
package lcd_pkg;

    // Panel geometry
    localparam int unsigned LCD_COLS  = 16;
    localparam int unsigned LCD_ROWS  = 2;
    localparam int unsigned LCD_CHARS = LCD_COLS * LCD_ROWS;
    localparam int unsigned LCD_IDX_W = 5;

    // Default fill character (ASCII space)
    localparam logic [7:0] LCD_SPACE = 8'h20;

    // DDRAM line base addresses and the mask selecting the line part of an address
    localparam logic [6:0] LINE1_BASE      = 7'h00;
    localparam logic [6:0] LINE2_BASE      = 7'h40;
    localparam logic [6:0] DDRAM_LINE_MASK = 7'h70;

    // Command classes, identified by the highest set bit of the command byte
    localparam logic [7:0] CMD_CLEAR_MASK   = 8'h01;
    localparam logic [7:0] CMD_HOME_MASK    = 8'h02;
    localparam logic [7:0] CMD_ENTRY_MASK   = 8'h04;
    localparam logic [7:0] CMD_DISPCTL_MASK = 8'h08;
    localparam logic [7:0] CMD_SHIFT_MASK   = 8'h10;
    localparam logic [7:0] CMD_FUNC_MASK    = 8'h20;
    localparam logic [7:0] CMD_CGRAM_MASK   = 8'h40;
    localparam logic [7:0] CMD_DDRAM_MASK   = 8'h80;

    // Bit positions inside the command byte
    localparam int unsigned ENTRY_ID_BIT = 1;
    localparam int unsigned DISP_ON_BIT  = 2;
    localparam int unsigned CUR_ON_BIT   = 1;
    localparam int unsigned BLINK_BIT    = 0;
    localparam int unsigned SHIFT_SC_BIT = 3;
    localparam int unsigned SHIFT_RL_BIT = 2;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_CLEAR,
        CLS_HOME,
        CLS_ENTRY,
        CLS_DISPCTL,
        CLS_SHIFT,
        CLS_FUNC,
        CLS_CGRAM,
        CLS_DDRAM
    } cmd_class_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_t;

    // Classify a command byte by its highest set bit
    function automatic cmd_class_t cmd_classify(input logic [7:0] d);
        cmd_class_t c;
        if      (|(d & CMD_DDRAM_MASK))   c = CLS_DDRAM;
        else if (|(d & CMD_CGRAM_MASK))   c = CLS_CGRAM;
        else if (|(d & CMD_FUNC_MASK))    c = CLS_FUNC;
        else if (|(d & CMD_SHIFT_MASK))   c = CLS_SHIFT;
        else if (|(d & CMD_DISPCTL_MASK)) c = CLS_DISPCTL;
        else if (|(d & CMD_ENTRY_MASK))   c = CLS_ENTRY;
        else if (|(d & CMD_HOME_MASK))    c = CLS_HOME;
        else if (|(d & CMD_CLEAR_MASK))   c = CLS_CLEAR;
        else                              c = CLS_NONE;
        return c;
    endfunction

    // Step a shadow index by +1/-1; the 5-bit width gives the 31<->0 wrap for free
    function automatic logic [LCD_IDX_W-1:0] idx_step(input logic [LCD_IDX_W-1:0] idx,
                                                     input logic up);
        return up ? idx + 5'd1 : idx - 5'd1;
    endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Synchronizes the LCD bus pins, detects the falling edge of E and presents
// the captured write transfer (reads are filtered out here).
module lcd_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data,
    output logic       xfer_valid,
    output logic       xfer_rs,
    output logic [7:0] xfer_data
);

    logic [SYNC_STAGES-1:0]      r_e_sync;
    logic [SYNC_STAGES-1:0]      r_rs_sync;
    logic [SYNC_STAGES-1:0]      r_rw_sync;
    logic [SYNC_STAGES-1:0][7:0] r_data_sync;
    logic                        r_e_prev;
    logic                        w_e_fall;

    // Synchronizer chains plus one extra E stage for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e_sync    <= '0;
            r_rs_sync   <= '0;
            r_rw_sync   <= '0;
            r_data_sync <= '0;
            r_e_prev    <= 1'b0;
        end else begin
            r_e_sync    <= {r_e_sync[SYNC_STAGES-2:0], lcd_e};
            r_rs_sync   <= {r_rs_sync[SYNC_STAGES-2:0], lcd_rs};
            r_rw_sync   <= {r_rw_sync[SYNC_STAGES-2:0], lcd_rw};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], lcd_data};
            r_e_prev    <= r_e_sync[SYNC_STAGES-1];
        end
    end

    // Falling edge of synchronized E qualifies a write transfer
    always_comb begin
        w_e_fall   = r_e_prev && !r_e_sync[SYNC_STAGES-1];
        xfer_valid = w_e_fall && !r_rw_sync[SYNC_STAGES-1];
        xfer_rs    = r_rs_sync[SYNC_STAGES-1];
        xfer_data  = r_data_sync[SYNC_STAGES-1];
    end

endmodule

// File: rtl/lcd_bus_capture.sv
// Passive HD44780-style bus responder keeping a 2x16 shadow of the display.
module lcd_bus_capture
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CLR_CHAR    = LCD_SPACE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lcd_rs,
    input  logic                 lcd_rw,
    input  logic                 lcd_e,
    input  logic [7:0]           lcd_data,
    input  logic [LCD_IDX_W-1:0] rd_index,
    output logic [7:0]           rd_char,
    output logic [LCD_IDX_W-1:0] cursor,
    output logic                 disp_on,
    output logic                 cursor_on,
    output logic                 blink_on,
    output logic                 init_done,
    output logic                 busy,
    output logic                 wr_strobe,
    output logic                 err
);

    logic                 w_xfer_valid;
    logic                 w_xfer_rs;
    logic [7:0]           w_xfer_data;

    clr_state_t           r_state;
    clr_state_t           w_state_nxt;
    logic [LCD_IDX_W-1:0] r_clr_idx;
    logic                 w_busy;
    logic                 w_clr_we;
    logic                 w_clr_done;
    logic                 w_exec_en;

    logic                 r_pend_valid;
    logic                 r_pend_rs;
    logic [7:0]           r_pend_data;

    logic                 w_exec_valid;
    logic                 w_exec_rs;
    logic [7:0]           w_exec_data;
    cmd_class_t           w_exec_cls;
    logic                 w_data_wr;
    logic                 w_drop;
    logic [6:0]           w_ddram_addr;

    logic [LCD_IDX_W-1:0] r_cursor;
    logic                 r_id;
    logic                 r_cgram;
    logic                 r_disp_on;
    logic                 r_cursor_on;
    logic                 r_blink_on;
    logic                 r_init_done;
    logic                 r_err;
    logic                 r_wr_strobe;
    logic [7:0]           r_rd_char;
    logic [7:0]           r_ram [LCD_CHARS];

    lcd_strobe_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_data  (lcd_data),
        .xfer_valid(w_xfer_valid),
        .xfer_rs   (w_xfer_rs),
        .xfer_data (w_xfer_data)
    );

    // Clear sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Clear sequencer next state: 32 cycles of CLEAR, one index per cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_exec_valid && !w_exec_rs && w_exec_cls == CLS_CLEAR)
                          w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_clr_idx == 5'd31)
                          w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Clear sequencer outputs
    always_comb begin
        w_busy     = (r_state == ST_CLEAR);
        w_clr_we   = w_busy;
        w_clr_done = w_busy && (r_clr_idx == 5'd31);
        w_exec_en  = (r_state == ST_IDLE);
    end

    // A held transfer takes priority over a fresh one once the Clear is over
    always_comb begin
        w_exec_valid = w_exec_en && (r_pend_valid || w_xfer_valid);
        w_exec_rs    = r_pend_valid ? r_pend_rs   : w_xfer_rs;
        w_exec_data  = r_pend_valid ? r_pend_data : w_xfer_data;
        w_exec_cls   = cmd_classify(w_exec_data);
        w_data_wr    = w_exec_valid && w_exec_rs && !r_cgram;
        w_drop       = w_busy && w_xfer_valid && r_pend_valid;
        w_ddram_addr = w_exec_data[6:0];
    end

    // Pending slot: fills during Clear; refills if a transfer lands while it drains
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_valid <= 1'b0;
            r_pend_rs    <= 1'b0;
            r_pend_data  <= '0;
        end else if (w_busy) begin
            if (w_xfer_valid && !r_pend_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_rs    <= w_xfer_rs;
                r_pend_data  <= w_xfer_data;
            end
        end else if (r_pend_valid) begin
            if (w_xfer_valid) begin
                r_pend_rs   <= w_xfer_rs;
                r_pend_data <= w_xfer_data;
            end else begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Decoder: cursor, entry mode, display flags, sticky status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clr_idx   <= '0;
            r_cursor    <= '0;
            r_id        <= 1'b1;
            r_cgram     <= 1'b0;
            r_disp_on   <= 1'b0;
            r_cursor_on <= 1'b0;
            r_blink_on  <= 1'b0;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
            r_wr_strobe <= 1'b0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_clr_we) r_clr_idx <= r_clr_idx + 5'd1;
            if (w_clr_done) begin
                r_cursor <= '0;
                r_id     <= 1'b1;
            end
            if (w_drop) r_err <= 1'b1;
            if (w_exec_valid) begin
                if (w_exec_rs) begin
                    if (!r_cgram) begin
                        r_wr_strobe <= 1'b1;
                        r_cursor    <= idx_step(r_cursor, r_id);
                    end
                end else begin
                    case (w_exec_cls)
                        CLS_HOME:    r_cursor <= '0;
                        CLS_ENTRY:   r_id     <= w_exec_data[ENTRY_ID_BIT];
                        CLS_DISPCTL: begin
                            r_disp_on   <= w_exec_data[DISP_ON_BIT];
                            r_cursor_on <= w_exec_data[CUR_ON_BIT];
                            r_blink_on  <= w_exec_data[BLINK_BIT];
                        end
                        CLS_SHIFT:   if (!w_exec_data[SHIFT_SC_BIT])
                                         r_cursor <= idx_step(r_cursor, w_exec_data[SHIFT_RL_BIT]);
                        CLS_FUNC:    r_init_done <= 1'b1;
                        CLS_CGRAM:   r_cgram     <= 1'b1;
                        CLS_DDRAM: begin
                            r_cgram <= 1'b0;
                            if ((w_ddram_addr & DDRAM_LINE_MASK) == LINE1_BASE)
                                r_cursor <= {1'b0, w_ddram_addr[3:0]};
                            else if ((w_ddram_addr & DDRAM_LINE_MASK) == LINE2_BASE)
                                r_cursor <= {1'b1, w_ddram_addr[3:0]};
                            else
                                r_err <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Shadow RAM: Clear sweep or data write (never both, states are exclusive)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LCD_CHARS; i++) r_ram[i[4:0]] <= CLR_CHAR;
        end else if (w_clr_we) begin
            r_ram[r_clr_idx] <= CLR_CHAR;
        end else if (w_data_wr) begin
            r_ram[r_cursor] <= w_exec_data;
        end
    end

    // Registered read port; a same-cycle write shows up one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rd_char <= CLR_CHAR;
        else      r_rd_char <= r_ram[rd_index];
    end

    assign rd_char   = r_rd_char;
    assign cursor    = r_cursor;
    assign disp_on   = r_disp_on;
    assign cursor_on = r_cursor_on;
    assign blink_on  = r_blink_on;
    assign init_done = r_init_done;
    assign busy      = w_busy;
    assign wr_strobe = r_wr_strobe;
    assign err       = r_err;

endmodule
